// File: rtl/it_seq_unit.sv
// it_seq_unit: Thumb-2 IT-block sequencer for a multi-issue decode stage.
// Owns ITSTATE, evaluates each slot's condition against APSR and marks
// slots that must execute as NOP. Saves ITSTATE on exception entry and
// restores it on exception return.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   it_valid, it_imm           slot 0 holds an IT instruction ({firstcond, mask})
//   ins_valid, flag_wr         per-slot non-IT instruction / writes APSR flags
//   apsr                       {N,Z,C,V,Q}
//   exc_entry, exc_return      exception entry / return pulses
//   flush                      taken branch out of an IT block
//   slot_accept                per-slot consumed this cycle
//   slot_cond                  per-slot effective condition (4 bits each)
//   slot_skip                  per-slot execute as NOP
//   slot_last                  per-slot last instruction of its IT block
//   in_it, itstate             architectural ITSTATE and its in-block flag
//   stk_full, stk_empty        save-stack status
//   err                        sticky {underflow, overflow, bad IT}

// Per-slot condition evaluation and one-step ITSTATE advance.
module it_seq_slot (
    input  logic [7:0] s,
    input  logic [4:0] apsr,
    output logic [3:0] cond,
    output logic       skip,
    output logic       last,
    output logic       active,
    output logic [7:0] s_adv
);
    logic n, z, c, v, pass, base;
    logic unused_q;

    assign n = apsr[4];
    assign z = apsr[3];
    assign c = apsr[2];
    assign v = apsr[1];
    assign unused_q = apsr[0];

    assign active = |s[3:0];
    assign cond   = active ? s[7:4] : 4'b1110;
    assign last   = (s[3:0] == 4'b1000);
    // Advancing shifts the mask (and firstcond LSB) left; an exhausted
    // block collapses to zero.
    assign s_adv  = (s[2:0] == 3'b000) ? 8'h00 : {s[7:5], s[3:0], 1'b0};

    always_comb begin
        base = 1'b1;
        case (cond[3:1])
            3'b000:  base = z;
            3'b001:  base = c;
            3'b010:  base = n;
            3'b011:  base = v;
            3'b100:  base = c & ~z;
            3'b101:  base = (n == v);
            3'b110:  base = (n == v) & ~z;
            default: base = 1'b1;
        endcase
        pass = (cond[0] && cond != 4'hF) ? ~base : base;
    end

    assign skip = active & ~pass;
endmodule

module it_seq_unit #(
    parameter int ISSUE_W    = 2,
    parameter int SAVE_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   it_valid,
    input  logic [7:0]             it_imm,
    input  logic [ISSUE_W-1:0]     ins_valid,
    input  logic [ISSUE_W-1:0]     flag_wr,
    input  logic [4:0]             apsr,
    input  logic                   exc_entry,
    input  logic                   exc_return,
    input  logic                   flush,
    output logic [ISSUE_W-1:0]     slot_accept,
    output logic [4*ISSUE_W-1:0]   slot_cond,
    output logic [ISSUE_W-1:0]     slot_skip,
    output logic [ISSUE_W-1:0]     slot_last,
    output logic                   in_it,
    output logic [7:0]             itstate,
    output logic                   stk_full,
    output logic                   stk_empty,
    output logic [2:0]             err
);
    localparam int AW = $clog2(SAVE_DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]           st [ISSUE_W+1];
    logic [ISSUE_W-1:0]   act, skp, lst, acc, skip_all;
    logic [4*ISSUE_W-1:0] cnd;
    logic                 blocked, it_bad, it_load, fw_older;
    logic [7:0]           adv;
    logic [7:0]           stk [SAVE_DEPTH];
    logic [CW-1:0]        cnt, cnt_dec;
    logic                 unused_fw;

    // Slot i sees ITSTATE advanced i times.
    assign st[0] = itstate;
    for (genvar i = 0; i < ISSUE_W; i++) begin : g_slot
        it_seq_slot u_slot (
            .s      (st[i]),
            .apsr   (apsr),
            .cond   (cnd[4*i +: 4]),
            .skip   (skp[i]),
            .last   (lst[i]),
            .active (act[i]),
            .s_adv  (st[i+1])
        );
    end

    assign blocked = exc_entry | exc_return | flush;
    // IT inside an IT block or with an empty mask executes as NOP.
    assign it_bad  = it_valid & (act[0] | (it_imm[3:0] == 4'h0));
    assign it_load = acc[0] & it_valid & ~it_bad;
    // The youngest slot's flag write only affects the following cycle.
    assign unused_fw = flag_wr[ISSUE_W-1];

    always_comb begin
        acc      = '0;
        fw_older = 1'b0;
        acc[0]   = (ins_valid[0] | it_valid) & ~blocked;
        for (int i = 1; i < ISSUE_W; i++) begin
            fw_older = fw_older | flag_wr[i-1];
            // A conditional slot must see flags written by an older slot.
            acc[i] = acc[i-1] & ~it_valid & ins_valid[i] & ~(act[i] & fw_older);
        end
    end

    // Accepts form a thermometer code, so the last accepted slot picks
    // how far ITSTATE advances.
    always_comb begin
        adv = st[0];
        for (int i = 0; i < ISSUE_W; i++)
            if (acc[i]) adv = st[i+1];
    end

    always_comb begin
        skip_all    = skp;
        skip_all[0] = skp[0] | it_bad;
    end

    assign stk_full  = (cnt == CW'(SAVE_DEPTH));
    assign stk_empty = (cnt == '0);
    assign cnt_dec   = cnt - CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            itstate <= 8'h00;
            cnt     <= '0;
            err     <= 3'b000;
            for (int k = 0; k < SAVE_DEPTH; k++) stk[k] <= 8'h00;
        end else if (exc_entry) begin
            itstate <= 8'h00;
            if (stk_full) begin
                err[1] <= 1'b1;
            end else begin
                stk[cnt[AW-1:0]] <= itstate;
                cnt              <= cnt + CW'(1);
            end
        end else if (exc_return) begin
            if (stk_empty) begin
                err[2]  <= 1'b1;
                itstate <= 8'h00;
            end else begin
                itstate <= stk[cnt_dec[AW-1:0]];
                cnt     <= cnt_dec;
            end
        end else if (flush) begin
            itstate <= 8'h00;
        end else if (it_load) begin
            itstate <= it_imm;
        end else begin
            itstate <= adv;
            if (acc[0] & it_bad) err[0] <= 1'b1;
        end
    end

    // Slot outputs are held at zero while reset is asserted.
    assign slot_accept = rst_n ? acc      : '0;
    assign slot_cond   = rst_n ? cnd      : '0;
    assign slot_skip   = rst_n ? skip_all : '0;
    assign slot_last   = rst_n ? lst      : '0;
    assign in_it       = act[0];
endmodule

// File: tb/tb_it_seq_unit.sv
module tb_it_seq_unit;
    localparam int IW = 2;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          it_valid;
    logic [7:0]    it_imm;
    logic [IW-1:0] ins_valid, flag_wr;
    logic [4:0]    apsr;
    logic          exc_entry, exc_return, flush;
    logic [IW-1:0] slot_accept, slot_skip, slot_last;
    logic [4*IW-1:0] slot_cond;
    logic          in_it, stk_full, stk_empty;
    logic [7:0]    itstate;
    logic [2:0]    err;

    it_seq_unit #(.ISSUE_W(IW), .SAVE_DEPTH(SD)) dut (
        .clk(clk), .rst_n(rst_n), .it_valid(it_valid), .it_imm(it_imm),
        .ins_valid(ins_valid), .flag_wr(flag_wr), .apsr(apsr),
        .exc_entry(exc_entry), .exc_return(exc_return), .flush(flush),
        .slot_accept(slot_accept), .slot_cond(slot_cond), .slot_skip(slot_skip),
        .slot_last(slot_last), .in_it(in_it), .itstate(itstate),
        .stk_full(stk_full), .stk_empty(stk_empty), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        itv;
        logic [7:0]  imm;
        logic [1:0]  ins, fw;
        logic [4:0]  apsr;
        logic        ee, er, fl;
        logic [1:0]  acc;
        logic [7:0]  cond;
        logic [1:0]  skip, last;
        logic [7:0]  nxt;
        logic [2:0]  err;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic itv, input logic [7:0] imm, input logic [1:0] ins,
                                input logic [1:0] fw, input logic [4:0] ap, input logic ee,
                                input logic er, input logic fl, input logic [1:0] acc,
                                input logic [7:0] cond, input logic [1:0] skip,
                                input logic [1:0] last, input logic [7:0] nxt,
                                input logic [2:0] e);
        vec_t v;
        v.itv = itv; v.imm = imm; v.ins = ins; v.fw = fw; v.apsr = ap;
        v.ee = ee; v.er = er; v.fl = fl; v.acc = acc; v.cond = cond;
        v.skip = skip; v.last = last; v.nxt = nxt; v.err = e;
        return v;
    endfunction

    task automatic idle();
        it_valid = 1'b0; it_imm = 8'h00; ins_valid = '0; flag_wr = '0;
        exc_entry = 1'b0; exc_return = 1'b0; flush = 1'b0;
    endtask

    task automatic step(input logic itv, input logic [7:0] imm, input logic [1:0] ins,
                        input logic ee, input logic er, input logic fl);
        @(negedge clk);
        idle();
        it_valid = itv; it_imm = imm; ins_valid = ins;
        exc_entry = ee; exc_return = er; flush = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t e;
        // itv imm ins fw apsr ee er fl | acc cond skip last nxt err
        tbl.push_back(mk(0, 8'h00, 2'b00, 2'b00, 5'h00, 0,0,0, 2'b00, 8'hEE, 2'b00, 2'b00, 8'h00, 3'b000));
        tbl.push_back(mk(1, 8'h08, 2'b00, 2'b00, 5'h08, 0,0,0, 2'b01, 8'hEE, 2'b00, 2'b00, 8'h08, 3'b000));
        tbl.push_back(mk(0, 8'h00, 2'b01, 2'b00, 5'h08, 0,0,0, 2'b01, 8'hE0, 2'b00, 2'b01, 8'h00, 3'b000));
        tbl.push_back(mk(1, 8'h06, 2'b00, 2'b00, 5'h08, 0,0,0, 2'b01, 8'hEE, 2'b00, 2'b00, 8'h06, 3'b000));
        tbl.push_back(mk(0, 8'h00, 2'b11, 2'b00, 5'h08, 0,0,0, 2'b11, 8'h00, 2'b00, 2'b00, 8'h18, 3'b000));
        tbl.push_back(mk(0, 8'h00, 2'b11, 2'b00, 5'h08, 0,0,0, 2'b11, 8'hE1, 2'b01, 2'b01, 8'h00, 3'b000));
        tbl.push_back(mk(1, 8'hA4, 2'b00, 2'b00, 5'h00, 0,0,0, 2'b01, 8'hEE, 2'b00, 2'b00, 8'hA4, 3'b000));
        tbl.push_back(mk(0, 8'h00, 2'b11, 2'b01, 5'h00, 0,0,0, 2'b01, 8'hAA, 2'b00, 2'b10, 8'hA8, 3'b000));
        tbl.push_back(mk(0, 8'h00, 2'b01, 2'b00, 5'h10, 0,0,0, 2'b01, 8'hEA, 2'b01, 2'b01, 8'h00, 3'b000));
        tbl.push_back(mk(1, 8'h06, 2'b00, 2'b00, 5'h08, 0,0,0, 2'b01, 8'hEE, 2'b00, 2'b00, 8'h06, 3'b000));
        tbl.push_back(mk(0, 8'h00, 2'b01, 2'b00, 5'h08, 0,0,0, 2'b01, 8'h00, 2'b00, 2'b00, 8'h0C, 3'b000));
        tbl.push_back(mk(0, 8'h00, 2'b01, 2'b00, 5'h08, 1,0,0, 2'b00, 8'h10, 2'b10, 2'b10, 8'h00, 3'b000));
        tbl.push_back(mk(0, 8'h00, 2'b00, 2'b00, 5'h08, 0,1,0, 2'b00, 8'hEE, 2'b00, 2'b00, 8'h0C, 3'b000));
        tbl.push_back(mk(1, 8'h08, 2'b00, 2'b00, 5'h08, 0,0,0, 2'b01, 8'h10, 2'b11, 2'b10, 8'h18, 3'b001));
        tbl.push_back(mk(0, 8'h00, 2'b01, 2'b00, 5'h08, 0,0,1, 2'b00, 8'hE1, 2'b01, 2'b01, 8'h00, 3'b001));
        tbl.push_back(mk(1, 8'h40, 2'b00, 2'b00, 5'h00, 0,0,0, 2'b01, 8'hEE, 2'b01, 2'b00, 8'h00, 3'b001));
        tbl.push_back(mk(1, 8'h88, 2'b00, 2'b00, 5'h04, 0,0,0, 2'b01, 8'hEE, 2'b00, 2'b00, 8'h88, 3'b001));
        tbl.push_back(mk(0, 8'h00, 2'b01, 2'b00, 5'h04, 0,0,0, 2'b01, 8'hE8, 2'b00, 2'b01, 8'h00, 3'b001));

        // Reset state, with instructions offered to prove outputs are held.
        rst_n = 1'b0;
        idle();
        apsr = 5'h08;
        ins_valid = 2'b11;
        #12;
        chk("rst_accept", 32'(slot_accept), 32'h0);
        chk("rst_cond", 32'(slot_cond), 32'h0);
        chk("rst_itstate", 32'(itstate), 32'h0);
        chk("rst_empty", 32'(stk_empty), 32'h1);
        chk("rst_err", 32'(err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        foreach (tbl[k]) begin
            @(negedge clk);
            idle();
            it_valid = tbl[k].itv; it_imm = tbl[k].imm; ins_valid = tbl[k].ins;
            flag_wr = tbl[k].fw; apsr = tbl[k].apsr;
            exc_entry = tbl[k].ee; exc_return = tbl[k].er; flush = tbl[k].fl;
            sb.push_back(tbl[k]);
            #2;
            e = sb.pop_front();
            chk($sformatf("v%0d_accept", k), 32'(slot_accept), 32'(e.acc));
            chk($sformatf("v%0d_cond", k), 32'(slot_cond), 32'(e.cond));
            chk($sformatf("v%0d_skip", k), 32'(slot_skip), 32'(e.skip));
            chk($sformatf("v%0d_last", k), 32'(slot_last), 32'(e.last));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_itstate", k), 32'(itstate), 32'(e.nxt));
            chk($sformatf("v%0d_in_it", k), 32'(in_it), 32'(e.nxt[3:0] != 4'h0));
            chk($sformatf("v%0d_err", k), 32'(err), 32'(e.err));
        end

        // Clear sticky errors.
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        #1;
        chk("rst2_err", 32'(err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apsr = 5'h08;

        // Coincident entry and return: only the entry happens.
        step(1, 8'h08, 2'b00, 0, 0, 0);
        chk("co_load", 32'(itstate), 32'h08);
        step(0, 8'h00, 2'b00, 1, 1, 0);
        chk("co_itstate", 32'(itstate), 32'h00);
        chk("co_empty", 32'(stk_empty), 32'h0);
        step(0, 8'h00, 2'b00, 0, 1, 0);
        chk("co_restore", 32'(itstate), 32'h08);
        chk("co_empty2", 32'(stk_empty), 32'h1);

        // Overflow: first push saves 0x08, the rest save 0.
        for (int i = 0; i < SD; i++) step(0, 8'h00, 2'b00, 1, 0, 0);
        chk("ov_full", 32'(stk_full), 32'h1);
        chk("ov_err_pre", 32'(err), 32'h0);
        step(0, 8'h00, 2'b00, 1, 0, 0);
        chk("ov_err", 32'(err), 32'h2);
        for (int i = 0; i < SD; i++) step(0, 8'h00, 2'b00, 0, 1, 0);
        chk("un_oldest", 32'(itstate), 32'h08);
        chk("un_empty", 32'(stk_empty), 32'h1);
        step(0, 8'h00, 2'b00, 0, 1, 0);
        chk("un_err", 32'(err), 32'h6);
        chk("un_itstate", 32'(itstate), 32'h00);

        // Asynchronous reset mid-block, between clock edges.
        step(1, 8'h06, 2'b00, 0, 0, 0);
        chk("ar_load", 32'(itstate), 32'h06);
        @(negedge clk);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_itstate", 32'(itstate), 32'h00);
        chk("ar_err", 32'(err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
